// File: rtl/pong_motion_ctrl.sv
// Per-frame paddle and ball motion sequencer for the Pong object generators.
// One update per frame tick; outputs are registered and change one clock after the tick.
module pong_motion_ctrl #(
    parameter int BAR_V       = 4,
    parameter int BALL_V      = 2,
    parameter int MISS_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       launch,
    output logic [9:0] bar_y_t,
    output logic [9:0] ball_x_l,
    output logic [9:0] ball_y_t,
    output logic       playing,
    output logic       hit,
    output logic       miss,
    output logic [6:0] hit_count
);

    localparam logic [9:0] BAR_STEP   = 10'(BAR_V);
    localparam logic [9:0] BALL_STEP  = 10'(BALL_V);
    localparam logic [9:0] BAR_Y_RST  = 10'd204;
    localparam logic [9:0] BALL_X_RST = 10'd580;
    localparam logic [9:0] BALL_Y_RST = 10'd238;
    localparam logic [7:0] MISS_LAST  = 8'(MISS_FRAMES - 1);

    typedef enum logic [1:0] {ST_SERVE, ST_PLAY, ST_MISS} state_t;

    state_t     state_q, state_d;
    logic [9:0] bar_y_q, bar_y_d;
    logic [9:0] ball_x_q, ball_x_d;
    logic [9:0] ball_y_q, ball_y_d;
    logic       vx_neg_q, vx_neg_d;   // 1: ball moving left
    logic       vy_neg_q, vy_neg_d;   // 1: ball moving up
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [6:0] hit_count_q, hit_count_d;
    logic       hit_q, hit_d;
    logic       miss_q, miss_d;
    logic       ref_d_q, ref_d_d;

    logic       ref_pos;
    logic       tick;
    logic [9:0] ball_r;
    logic [9:0] ball_b;
    logic       paddle_hit;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_SERVE;
            bar_y_q     <= BAR_Y_RST;
            ball_x_q    <= BALL_X_RST;
            ball_y_q    <= BALL_Y_RST;
            vx_neg_q    <= 1'b1;
            vy_neg_q    <= 1'b0;
            frame_cnt_q <= 8'd0;
            hit_count_q <= 7'd0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            ref_d_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bar_y_q     <= bar_y_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            vx_neg_q    <= vx_neg_d;
            vy_neg_q    <= vy_neg_d;
            frame_cnt_q <= frame_cnt_d;
            hit_count_q <= hit_count_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            ref_d_q     <= ref_d_d;
        end
    end

    always_comb begin
        ref_pos     = (pixel_x == 10'd0) && (pixel_y == 10'd481);
        tick        = ref_pos & ~ref_d_q;
        ref_d_d     = ref_pos;
        ball_r      = ball_x_q + 10'd8;
        ball_b      = ball_y_q + 10'd8;
        paddle_hit  = !vx_neg_q && (ball_r >= 10'd600) && (ball_r <= 10'd603) &&
                      (ball_b >= bar_y_q) && (ball_y_q <= bar_y_q + 10'd72);
        state_d     = state_q;
        bar_y_d     = bar_y_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        vx_neg_d    = vx_neg_q;
        vy_neg_d    = vy_neg_q;
        frame_cnt_d = frame_cnt_q;
        hit_count_d = hit_count_q;
        hit_d       = 1'b0;
        miss_d      = 1'b0;

        if (tick) begin
            if (btn_down && !btn_up && (bar_y_q <= 10'd398)) begin
                bar_y_d = bar_y_q + BAR_STEP;
            end else if (btn_up && !btn_down && (bar_y_q >= 10'd10)) begin
                bar_y_d = bar_y_q - BAR_STEP;
            end

            case (state_q)
                ST_SERVE: begin
                    if (launch) begin
                        state_d = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (ball_r >= 10'd632) begin
                        state_d     = ST_MISS;
                        miss_d      = 1'b1;
                        frame_cnt_d = 8'd0;
                    end else begin
                        // Wall and paddle reflections are evaluated independently so corners flip both axes.
                        if (ball_y_q <= 10'd6) begin
                            vy_neg_d = 1'b0;
                        end else if (ball_b >= 10'd474) begin
                            vy_neg_d = 1'b1;
                        end
                        if (ball_x_q <= 10'd36) begin
                            vx_neg_d = 1'b0;
                        end
                        if (paddle_hit) begin
                            vx_neg_d = 1'b1;
                            hit_d    = 1'b1;
                            if (hit_count_q != 7'd127) begin
                                hit_count_d = hit_count_q + 7'd1;
                            end
                        end
                        ball_x_d = vx_neg_d ? ball_x_q - BALL_STEP : ball_x_q + BALL_STEP;
                        ball_y_d = vy_neg_d ? ball_y_q - BALL_STEP : ball_y_q + BALL_STEP;
                    end
                end
                ST_MISS: begin
                    if (frame_cnt_q == MISS_LAST) begin
                        state_d     = ST_SERVE;
                        ball_x_d    = BALL_X_RST;
                        ball_y_d    = BALL_Y_RST;
                        vx_neg_d    = 1'b1;
                        vy_neg_d    = 1'b0;
                        hit_count_d = 7'd0;
                        frame_cnt_d = 8'd0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = ST_SERVE;
                end
            endcase
        end
    end

    always_comb begin
        playing   = (state_q == ST_PLAY);
        bar_y_t   = bar_y_q;
        ball_x_l  = ball_x_q;
        ball_y_t  = ball_y_q;
        hit       = hit_q;
        miss      = miss_q;
        hit_count = hit_count_q;
    end

endmodule
